// File: rtl/rf_write_arbiter_if.sv
// Write-request handshake bundle for the two writeback requesters (A = ALU, B = load).
// The master modport belongs to the requesters and the slave modport to the arbiter.
interface rf_write_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register-bank write port, shared by ALU (A) and load (B) writeback.
// Outputs a registered one-hot enable and data bus, an out-of-range pulse and a saturating conflict count.
module rf_write_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  rf_write_arbiter_if.slave   req,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic                addr_err,
  output logic [7:0]          conflict_cnt
);
  // state  | meaning
  // LAST_A | A was granted most recently; B wins the next conflict
  // LAST_B | B was granted most recently (reset); A wins the next conflict
  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} grant_t;

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  grant_t              state;
  grant_t              state_nxt;
  logic                a_grant;
  logic                b_grant;
  logic                xfer;
  logic                in_range;
  logic                both_req;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] wr_en_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LAST_B;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_grant   = 1'b0;
    b_grant   = 1'b0;
    if (reset && !stall) begin
      a_grant = req.a_valid && (!req.b_valid || state == LAST_B);
      b_grant = req.b_valid && (!req.a_valid || state == LAST_A);
    end
    if (a_grant) begin
      state_nxt = LAST_A;
    end else if (b_grant) begin
      state_nxt = LAST_B;
    end
  end

  assign req.a_ready = a_grant;
  assign req.b_ready = b_grant;

  assign xfer     = a_grant || b_grant;
  assign sel_addr = a_grant ? req.a_addr : req.b_addr;
  assign sel_data = a_grant ? req.a_data : req.b_data;
  assign in_range = {1'b0, sel_addr} < NUM_REGS_W;
  assign both_req = req.a_valid && req.b_valid && !stall;

  // Out-of-range writes are still accepted but never reach the bank.
  always_comb begin
    wr_en_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_en_nxt[i] = xfer && in_range && (sel_addr == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en        <= '0;
      wr_data      <= '0;
      addr_err     <= 1'b0;
      conflict_cnt <= 8'd0;
    end else begin
      wr_en    <= wr_en_nxt;
      addr_err <= xfer && !in_range;
      if (xfer && in_range) begin
        wr_data <= sel_data;
      end
      if (both_req && conflict_cnt != 8'hFF) begin
        conflict_cnt <= conflict_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a rule-level reference model.
module tb_rf_write_arbiter;
  localparam int NUM_REGS = 12;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;

  logic                clk   = 1'b0;
  logic                reset = 1'b0;
  logic                stall = 1'b0;
  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic                addr_err;
  logic [7:0]          conflict_cnt;

  rf_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rif ();

  rf_write_arbiter #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .req          (rif),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .addr_err     (addr_err),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns priority, what the bank sees next cycle, and the bank contents.
  logic                m_prio_a = 1'b1;
  logic [NUM_REGS-1:0] m_en     = '0;
  logic [DATA_W-1:0]   m_data   = '0;
  logic                m_err    = 1'b0;
  int                  m_cnt    = 0;
  logic [DATA_W-1:0]   m_bank   [NUM_REGS];
  logic [DATA_W-1:0]   dut_bank [NUM_REGS];
  logic [1:0]          g_mod;
  logic [1:0]          g_cmp;
  int                  w_addr;
  logic [DATA_W-1:0]   w_data;

  function automatic logic [1:0] exp_grant();
    logic ga, gb;
    ga = reset && !stall && rif.a_valid && (!rif.b_valid || m_prio_a);
    gb = reset && !stall && rif.b_valid && (!rif.a_valid || !m_prio_a);
    return {ga, gb};
  endfunction

  initial begin
    for (int i = 0; i < NUM_REGS; i++) begin
      m_bank[i]   = '0;
      dut_bank[i] = '0;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_prio_a <= 1'b1;
      m_en     <= '0;
      m_data   <= '0;
      m_err    <= 1'b0;
      m_cnt    <= 0;
    end else begin
      g_mod = exp_grant();
      w_addr = g_mod[1] ? int'(rif.a_addr) : int'(rif.b_addr);
      w_data = g_mod[1] ? rif.a_data : rif.b_data;
      if (g_mod != 2'b00) begin
        m_prio_a <= g_mod[0];
        if (w_addr < NUM_REGS) begin
          m_en           <= {{(NUM_REGS-1){1'b0}}, 1'b1} << w_addr;
          m_data         <= w_data;
          m_err          <= 1'b0;
          m_bank[w_addr] <= w_data;
        end else begin
          m_en  <= '0;
          m_err <= 1'b1;
        end
      end else begin
        m_en  <= '0;
        m_err <= 1'b0;
      end
      if (rif.a_valid && rif.b_valid && !stall) begin
        m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
    end
  end

  // What the bank actually receives, for the end-of-run content comparison.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en[i]) dut_bank[i] <= wr_data;
    end
  end

  always @(negedge clk) begin
    g_cmp = exp_grant();
    check("a_ready", rif.a_ready, g_cmp[1]);
    check("b_ready", rif.b_ready, g_cmp[0]);
    check("wr_en", wr_en, m_en);
    check("wr_data", wr_data, m_data);
    check("addr_err", addr_err, m_err);
    check("conflict_cnt", conflict_cnt, m_cnt);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    stall       = 1'b0;
    rif.a_valid = 1'b0;
    rif.a_addr  = '0;
    rif.a_data  = '0;
    rif.b_valid = 1'b0;
    rif.b_addr  = '0;
    rif.b_data  = '0;
  endtask

  // Leaves reset asserted across one rising edge; the caller releases it.
  task automatic apply_reset();
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  logic a_acc, b_acc;
  int   na, nb;

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cnt", conflict_cnt, 0);
    check("rst_ready", {rif.a_ready, rif.b_ready}, 2'b00);

    // First write after reset release
    @(posedge clk);
    #1;
    reset = 1'b1;
    rif.a_valid = 1'b1;
    rif.a_addr  = 4'd3;
    rif.a_data  = 32'hDEADBEEF;
    @(negedge clk);
    check("first_a_ready", rif.a_ready, 1);
    @(posedge clk);
    #1;
    rif.a_valid = 1'b0;
    @(negedge clk);
    check("first_wr_en", wr_en, 12'h008);
    check("first_wr_data", wr_data, 32'hDEADBEEF);
    @(negedge clk);
    check("first_wr_en_single", wr_en, 0);
    check("first_wr_data_hold", wr_data, 32'hDEADBEEF);

    // First conflict goes to A
    apply_reset();
    rif.a_valid = 1'b1; rif.a_addr = 4'd1; rif.a_data = 32'h11;
    rif.b_valid = 1'b1; rif.b_addr = 4'd2; rif.b_data = 32'h22;
    reset = 1'b1;
    @(negedge clk);
    check("conf_grant_a", {rif.a_ready, rif.b_ready}, 2'b10);
    @(posedge clk);
    #1;
    rif.a_valid = 1'b0;
    @(negedge clk);
    check("conf_grant_b", {rif.a_ready, rif.b_ready}, 2'b01);
    check("conf_wr_en_a", wr_en, 12'h002);
    check("conf_cnt", conflict_cnt, 1);
    @(posedge clk);
    #1;
    rif.b_valid = 1'b0;
    @(negedge clk);
    check("conf_wr_en_b", wr_en, 12'h004);
    check("conf_wr_data_b", wr_data, 32'h22);

    // Fairness: three writes each, alternating
    apply_reset();
    na = 0; nb = 0;
    rif.a_valid = 1'b1; rif.a_addr = 4'd3; rif.a_data = 32'hA0;
    rif.b_valid = 1'b1; rif.b_addr = 4'd6; rif.b_data = 32'hB0;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("fair_grant", {rif.a_ready, rif.b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      a_acc = rif.a_valid && rif.a_ready;
      b_acc = rif.b_valid && rif.b_ready;
      @(posedge clk);
      #1;
      if (a_acc) begin
        na++;
        if (na == 3) rif.a_valid = 1'b0;
        else begin rif.a_addr = ADDR_W'(3 + na); rif.a_data = 32'hA0 + 32'(na); end
      end
      if (b_acc) begin
        nb++;
        if (nb == 3) rif.b_valid = 1'b0;
        else begin rif.b_addr = ADDR_W'(6 + nb); rif.b_data = 32'hB0 + 32'(nb); end
      end
    end
    @(negedge clk);
    check("fair_cnt", conflict_cnt, 5);

    // Stall blocks both, then round-robin resumes with A
    @(posedge clk);
    #1;
    stall = 1'b1;
    rif.a_valid = 1'b1; rif.a_addr = 4'd7; rif.a_data = 32'h77;
    rif.b_valid = 1'b1; rif.b_addr = 4'd8; rif.b_data = 32'h88;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", {rif.a_ready, rif.b_ready}, 2'b00);
      check("stall_cnt", conflict_cnt, 5);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    @(negedge clk);
    check("unstall_grant", {rif.a_ready, rif.b_ready}, 2'b10);
    @(posedge clk);
    #1;
    rif.a_valid = 1'b0;
    @(negedge clk);
    check("unstall_grant_b", {rif.a_ready, rif.b_ready}, 2'b01);
    check("unstall_cnt", conflict_cnt, 6);
    @(posedge clk);
    #1;
    rif.b_valid = 1'b0;

    // Out-of-range write from B
    rif.b_valid = 1'b1; rif.b_addr = 4'hE; rif.b_data = 32'hEE;
    @(negedge clk);
    check("oor_b_ready", rif.b_ready, 1);
    @(posedge clk);
    #1;
    rif.b_valid = 1'b0;
    @(negedge clk);
    check("oor_wr_en", wr_en, 0);
    check("oor_err", addr_err, 1);
    check("oor_wr_data_hold", wr_data, 32'h88);
    @(negedge clk);
    check("oor_err_pulse", addr_err, 0);

    // Same-address conflict: loser lands last
    @(posedge clk);
    #1;
    rif.a_valid = 1'b1; rif.a_addr = 4'd5; rif.a_data = 32'h5A;
    rif.b_valid = 1'b1; rif.b_addr = 4'd5; rif.b_data = 32'h5B;
    @(negedge clk);
    check("same_grant_a", {rif.a_ready, rif.b_ready}, 2'b10);
    @(posedge clk);
    #1;
    rif.a_valid = 1'b0;
    @(negedge clk);
    check("same_grant_b", {rif.a_ready, rif.b_ready}, 2'b01);
    @(posedge clk);
    #1;
    rif.b_valid = 1'b0;
    @(negedge clk);
    check("same_final_en", wr_en, 12'h020);
    check("same_final_data", wr_data, 32'h5B);

    // Saturation, then asynchronous reset right after a transfer
    apply_reset();
    rif.a_valid = 1'b1; rif.a_addr = 4'd1; rif.a_data = 32'h1111;
    rif.b_valid = 1'b1; rif.b_addr = 4'd2; rif.b_data = 32'h2222;
    reset = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    @(negedge clk);
    check("sat_cnt", conflict_cnt, 255);
    @(posedge clk);
    #1;
    check("pre_reset_wr_en", (wr_en != 0), 1);
    #1;
    reset = 1'b0;
    #1;
    check("async_wr_en", wr_en, 0);
    check("async_cnt", conflict_cnt, 0);
    check("async_ready", {rif.a_ready, rif.b_ready}, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Randomized traffic with occasional stalls and async resets
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      a_acc = rif.a_valid && rif.a_ready;
      b_acc = rif.b_valid && rif.b_ready;
      @(posedge clk);
      #1;
      if (!rif.a_valid || a_acc) begin
        rif.a_valid = ($urandom_range(0, 99) < 70);
        rif.a_addr  = ADDR_W'($urandom_range(0, 15));
        rif.a_data  = $urandom;
      end
      if (!rif.b_valid || b_acc) begin
        rif.b_valid = ($urandom_range(0, 99) < 70);
        rif.b_addr  = ($urandom_range(0, 3) == 0) ? rif.a_addr : ADDR_W'($urandom_range(0, 15));
        rif.b_data  = $urandom;
      end
      stall = ($urandom_range(0, 7) == 0);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset = 1'b0;
    end
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REGS; i++) begin
      check("bank_content", dut_bank[i], m_bank[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
